// File: rtl/shared_net_arbiter.sv
// Round-robin arbiter sharing one registered single-bit net among NUM_REQ requesters.
// Optional hold timeout enabled by defining NET_ARB_TIMEOUT_EN.
module shared_net_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_d,
  output logic [NUM_REQ-1:0] grant,
  output logic               d,
  output logic               d_valid,
  output logic               busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               d_q, d_d;
  logic               d_valid_q, d_valid_d;
  logic [IDX_W-1:0]   win;
  logic               found;
  int                 idx;
  logic               others;

`ifdef NET_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^8'(MAX_HOLD);
`endif

  // Winner search starts just after the last owner and wraps.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  assign others = |(req & ~grant_q);

  // In GRANT the owner index is last_q, since last is updated on grant.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    d_d       = 1'b0;
    d_valid_d = 1'b0;
`ifdef NET_ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = NUM_REQ'(1) << win;
          last_d  = win;
`ifdef NET_ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (!req[last_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef NET_ARB_TIMEOUT_EN
        else if (hold_q == 8'(MAX_HOLD - 1) && others) begin
          state_d = IDLE;
          grant_d = '0;
        end
`endif
        else begin
          d_d       = req_d[last_q];
          d_valid_d = 1'b1;
`ifdef NET_ARB_TIMEOUT_EN
          hold_d    = (hold_q == 8'(MAX_HOLD - 1)) ? 8'd0 : hold_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

`ifndef NET_ARB_TIMEOUT_EN
  logic unused_others;
  assign unused_others = others;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      d_q       <= 1'b0;
      d_valid_q <= 1'b0;
`ifdef NET_ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
`ifdef NET_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign d       = d_q;
  assign d_valid = d_valid_q;
  assign busy    = (state_q == GRANT);
endmodule
